// File: rtl/banco_de_registros_multipuerto.sv
// ---------------------------------------------------------------------------
// banco_de_registros_multipuerto
//
// Parametrised multiport register file: N registers of W bits, two write
// ports (B has priority over A on the same address), two read ports with
// write-through bypass, optional hardwired-zero register 0, optional
// one-cycle registered read, and a per-register pending scoreboard that lets
// a sequencer reserve a destination and stall readers until it is written.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   we_a       write enable, port A
//   addr_wa    write address, port A
//   data_wa    write data, port A
//   we_b       write enable, port B (wins over A on the same address)
//   addr_wb    write address, port B
//   data_wb    write data, port B
//   addr_rs1   read address 1
//   addr_rs2   read address 2
//   rsv_valid  reserve request: mark rsv_addr pending
//   rsv_addr   register to reserve
//   rs1, rs2   read data
//   busy_rs1   register at addr_rs1 is pending
//   busy_rs2   register at addr_rs2 is pending
// ---------------------------------------------------------------------------
module banco_de_registros_multipuerto #(
    parameter int N        = 8,
    parameter int W        = 4,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_wa,
    input  logic [W-1:0]      data_wa,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_wb,
    input  logic [W-1:0]      data_wb,
    input  logic [ADDR_W-1:0] addr_rs1,
    input  logic [ADDR_W-1:0] addr_rs2,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [W-1:0]      rs1,
    output logic [W-1:0]      rs2,
    output logic              busy_rs1,
    output logic              busy_rs2
);

    localparam int IDX_W = $clog2(N);

    // One extra bit so that N itself (e.g. 32 with ADDR_W=5) is representable.
    localparam logic [ADDR_W:0] N_EXT = (ADDR_W + 1)'(N);

    typedef struct packed {
        logic         busy;
        logic [W-1:0] data;
    } rd_t;

    logic [W-1:0]     regs [N];
    logic [N-1:0]     pending;
    logic [N-1:0]     next_pending;
    logic             active_a;
    logic             active_b;
    logic             rsv_active;
    logic [IDX_W-1:0] wa_idx;
    logic [IDX_W-1:0] wb_idx;
    logic [IDX_W-1:0] rsv_idx;
    rd_t              rd1;
    rd_t              rd2;

    // The full address is compared, so out-of-range addresses never alias
    // onto a real register through their low bits.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < N_EXT);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A port only counts as active when its target is a real, writable register.
    always_comb begin
        active_a   = we_a && in_range(addr_wa) && !is_zero_reg(addr_wa);
        active_b   = we_b && in_range(addr_wb) && !is_zero_reg(addr_wb);
        rsv_active = rsv_valid && in_range(rsv_addr) && !is_zero_reg(rsv_addr);
        wa_idx     = addr_wa[IDX_W-1:0];
        wb_idx     = addr_wb[IDX_W-1:0];
        rsv_idx    = rsv_addr[IDX_W-1:0];
    end

    // Storage update. Port B is written after port A so that it wins when
    // both target the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (active_a) begin
                regs[wa_idx] <= data_wa;
            end
            if (active_b) begin
                regs[wb_idx] <= data_wb;
            end
        end
    end

    // Completing writes clear pending; a reservation applied last wins, since
    // a new producer supersedes the one completing in the same cycle.
    always_comb begin
        next_pending = pending;
        if (active_a) begin
            next_pending[wa_idx] = 1'b0;
        end
        if (active_b) begin
            next_pending[wb_idx] = 1'b0;
        end
        if (rsv_active) begin
            next_pending[rsv_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= next_pending;
        end
    end

    // Read lookup with write-through bypass. A write landing this cycle both
    // forwards its data and drops the busy flag, so a waiting reader can
    // proceed in the same cycle the producer completes.
    function automatic rd_t lookup(input logic [ADDR_W-1:0] addr);
        rd_t              r;
        logic [IDX_W-1:0] idx;
        logic             hit_a;
        logic             hit_b;
        r     = '0;
        idx   = addr[IDX_W-1:0];
        hit_a = active_a && (addr == addr_wa);
        hit_b = active_b && (addr == addr_wb);
        if (in_range(addr) && !is_zero_reg(addr)) begin
            if (hit_b) begin
                r.data = data_wb;
            end else if (hit_a) begin
                r.data = data_wa;
            end else begin
                r.data = regs[idx];
            end
            r.busy = pending[idx] && !hit_a && !hit_b;
        end
        return r;
    endfunction

    always_comb begin
        rd1 = lookup(addr_rs1);
        rd2 = lookup(addr_rs2);
    end

    // Data and busy go through the same stage so they always stay aligned.
    if (READ_REG != 0) begin : g_reg_read
        always_ff @(posedge clk) begin
            if (rst) begin
                rs1      <= '0;
                rs2      <= '0;
                busy_rs1 <= 1'b0;
                busy_rs2 <= 1'b0;
            end else begin
                rs1      <= rd1.data;
                rs2      <= rd2.data;
                busy_rs1 <= rd1.busy;
                busy_rs2 <= rd2.busy;
            end
        end
    end else begin : g_comb_read
        always_comb begin
            rs1      = rd1.data;
            rs2      = rd2.data;
            busy_rs1 = rd1.busy;
            busy_rs2 = rd2.busy;
        end
    end

endmodule

// File: tb/tb_banco_de_registros_multipuerto.sv
// ---------------------------------------------------------------------------
// tb_banco_de_registros_multipuerto
//
// Drives a combinational-read instance and a registered-read instance with
// the same inputs. Stimulus pushes hand-computed expected outputs into a
// scoreboard queue tagged with the cycle they must appear in; a separate
// monitor pops and compares them on the falling edge of that cycle.
// ---------------------------------------------------------------------------
module tb_banco_de_registros_multipuerto;

    localparam int N      = 8;
    localparam int W      = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              we_a;
    logic [ADDR_W-1:0] addr_wa;
    logic [W-1:0]      data_wa;
    logic              we_b;
    logic [ADDR_W-1:0] addr_wb;
    logic [W-1:0]      data_wb;
    logic [ADDR_W-1:0] addr_rs1;
    logic [ADDR_W-1:0] addr_rs2;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;

    logic [W-1:0] rs1_c, rs2_c, rs1_r, rs2_r;
    logic         busy1_c, busy2_c, busy1_r, busy2_r;

    typedef struct {
        string        name;
        int           due;
        bit           reg_inst;
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic         busy1;
        logic         busy2;
    } exp_t;

    exp_t sb[$];
    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    banco_de_registros_multipuerto #(
        .N(N), .W(W), .ADDR_W(ADDR_W), .ZERO_REG(1), .READ_REG(0)
    ) dut_comb (
        .clk(clk), .rst(rst),
        .we_a(we_a), .addr_wa(addr_wa), .data_wa(data_wa),
        .we_b(we_b), .addr_wb(addr_wb), .data_wb(data_wb),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rs1(rs1_c), .rs2(rs2_c), .busy_rs1(busy1_c), .busy_rs2(busy2_c)
    );

    banco_de_registros_multipuerto #(
        .N(N), .W(W), .ADDR_W(ADDR_W), .ZERO_REG(1), .READ_REG(1)
    ) dut_reg (
        .clk(clk), .rst(rst),
        .we_a(we_a), .addr_wa(addr_wa), .data_wa(data_wa),
        .we_b(we_b), .addr_wb(addr_wb), .data_wb(data_wb),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rs1(rs1_r), .rs2(rs2_r), .busy_rs1(busy1_r), .busy_rs2(busy2_r)
    );

    // Monitor: compare every entry due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            exp_t e;
            e = sb[i];
            if (e.due == cycle) begin
                logic [W-1:0] a1, a2;
                logic         b1, b2;
                a1 = e.reg_inst ? rs1_r   : rs1_c;
                a2 = e.reg_inst ? rs2_r   : rs2_c;
                b1 = e.reg_inst ? busy1_r : busy1_c;
                b2 = e.reg_inst ? busy2_r : busy2_c;
                checks++;
                if (a1 !== e.rs1 || a2 !== e.rs2 || b1 !== e.busy1 || b2 !== e.busy2) begin
                    failures++;
                    $display("[TB] FAIL %s (%s) cycle %0d: got rs1=%h rs2=%h busy1=%b busy2=%b, expected rs1=%h rs2=%h busy1=%b busy2=%b",
                             e.name, e.reg_inst ? "reg" : "comb", cycle,
                             a1, a2, b1, b2, e.rs1, e.rs2, e.busy1, e.busy2);
                end
                sb.delete(i);
            end else if (e.due < cycle) begin
                checks++;
                failures++;
                $display("[TB] FAIL %s overdue: got no check at cycle %0d, expected check at cycle %0d",
                         e.name, cycle, e.due);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push(input string name, input bit reg_inst, input int delay,
                        input logic [W-1:0] e1, input logic [W-1:0] e2,
                        input logic b1, input logic b2);
        exp_t e;
        e.name     = name;
        e.due      = cycle + delay;
        e.reg_inst = reg_inst;
        e.rs1      = e1;
        e.rs2      = e2;
        e.busy1    = b1;
        e.busy2    = b2;
        sb.push_back(e);
    endtask

    // The same tuple on the combinational instance now and on the registered
    // instance one cycle later.
    task automatic expect_both(input string name, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic b1, input logic b2);
        push(name, 1'b0, 0, e1, e2, b1, b2);
        push(name, 1'b1, 1, e1, e2, b1, b2);
    endtask

    task automatic set_reads(input int a1, input int a2);
        addr_rs1 = ADDR_W'(a1);
        addr_rs2 = ADDR_W'(a2);
    endtask

    task automatic write_a(input int a, input int d);
        we_a    = 1'b1;
        addr_wa = ADDR_W'(a);
        data_wa = W'(d);
    endtask

    task automatic write_b(input int a, input int d);
        we_b    = 1'b1;
        addr_wb = ADDR_W'(a);
        data_wb = W'(d);
    endtask

    task automatic reserve(input int a);
        rsv_valid = 1'b1;
        rsv_addr  = ADDR_W'(a);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        we_a      = 1'b0;
        we_b      = 1'b0;
        rsv_valid = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        we_a = 1'b0; addr_wa = '0; data_wa = '0;
        we_b = 1'b0; addr_wb = '0; data_wb = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
        addr_rs1 = '0; addr_rs2 = '0;
        @(posedge clk);
        next_cycle();

        // Reset state: every address reads 0, nothing busy.
        for (int a = 0; a < N; a++) begin
            set_reads(a, N - 1 - a);
            expect_both("reset_read", 4'h0, 4'h0, 1'b0, 1'b0);
            next_cycle();
        end

        // Write r3 via A, bypassed then stored.
        write_a(3, 4'hA); set_reads(3, 0);
        expect_both("wr_a_bypass", 4'hA, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 0);
        expect_both("wr_a_stored", 4'hA, 4'h0, 1'b0, 1'b0);
        next_cycle();

        // Both ports on r5: B wins.
        write_a(5, 4'h3); write_b(5, 4'hC); set_reads(5, 3);
        expect_both("prio_bypass", 4'hC, 4'hA, 1'b0, 1'b0);
        next_cycle();
        set_reads(5, 3);
        expect_both("prio_stored", 4'hC, 4'hA, 1'b0, 1'b0);
        next_cycle();

        // Zero register and out-of-range addresses.
        write_a(0, 4'hF); reserve(0); set_reads(0, 8);
        expect_both("zero_reg_wr", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        write_a(9, 4'h5); write_b(31, 4'h6); set_reads(8, 31);
        expect_both("out_of_range", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(0, 9);
        expect_both("zero_after", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(1, 7);
        expect_both("no_alias", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 5);
        expect_both("regs_kept", 4'hA, 4'hC, 1'b0, 1'b0);
        next_cycle();

        // Scoreboard on r2.
        reserve(2); set_reads(3, 2);
        expect_both("rsv_cycle", 4'hA, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 2);
        expect_both("rsv_busy", 4'hA, 4'h0, 1'b0, 1'b1);
        next_cycle();
        write_a(2, 4'h7); set_reads(3, 2);
        expect_both("wr_unbusy", 4'hA, 4'h7, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 2);
        expect_both("pend_clear", 4'hA, 4'h7, 1'b0, 1'b0);
        next_cycle();
        reserve(2); write_b(2, 4'h9); set_reads(3, 2);
        expect_both("rsv_and_wr", 4'hA, 4'h9, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 2);
        expect_both("rsv_wins", 4'hA, 4'h9, 1'b0, 1'b1);
        next_cycle();
        write_b(2, 4'h4); set_reads(3, 2);
        expect_both("wr_b_unbusy", 4'hA, 4'h4, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 2);
        expect_both("r2_final", 4'hA, 4'h4, 1'b0, 1'b0);
        next_cycle();

        // Both busy outputs on r6.
        reserve(6); set_reads(6, 6);
        expect_both("rsv6_cycle", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(6, 6);
        expect_both("busy_both", 4'h0, 4'h0, 1'b1, 1'b1);
        next_cycle();
        write_a(6, 4'h1); set_reads(6, 6);
        expect_both("wr6_unbusy", 4'h1, 4'h1, 1'b0, 1'b0);
        next_cycle();
        set_reads(6, 6);
        expect_both("r6_stored", 4'h1, 4'h1, 1'b0, 1'b0);
        next_cycle();

        // Registered-read alignment on r4.
        reserve(4); set_reads(4, 2);
        expect_both("rsv4_cycle", 4'h0, 4'h4, 1'b0, 1'b0);
        next_cycle();
        set_reads(4, 2);
        expect_both("r4_busy", 4'h0, 4'h4, 1'b1, 1'b0);
        next_cycle();
        write_a(4, 4'h9); set_reads(4, 2);
        expect_both("r4_bypass", 4'h9, 4'h4, 1'b0, 1'b0);
        next_cycle();
        set_reads(4, 2);
        expect_both("r4_stored", 4'h9, 4'h4, 1'b0, 1'b0);
        next_cycle();

        // Reset mid-operation with r1 written and pending.
        write_a(1, 4'h6); set_reads(1, 2);
        expect_both("r1_write", 4'h6, 4'h4, 1'b0, 1'b0);
        next_cycle();
        reserve(1); set_reads(1, 2);
        expect_both("r1_rsv", 4'h6, 4'h4, 1'b0, 1'b0);
        next_cycle();
        set_reads(1, 2);
        expect_both("r1_busy", 4'h6, 4'h4, 1'b1, 1'b0);
        next_cycle();
        rst = 1'b1; write_a(1, 4'h2); set_reads(1, 2);
        push("rst_cycle", 1'b0, 0, 4'h2, 4'h4, 1'b0, 1'b0);
        push("rst_cycle", 1'b1, 1, 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(1, 2);
        expect_both("after_rst", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        set_reads(3, 5);
        expect_both("after_rst2", 4'h0, 4'h0, 1'b0, 1'b0);
        next_cycle();

        repeat (3) next_cycle();
        while (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s never checked: got pending entry, expected check at cycle %0d",
                     sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banco_de_registros_multipuerto.md
Name: banco_de_registros_multipuerto

Overview:
Parametrised successor of the team's 8x4 register file.
- N registers of W bits.
- Two write ports with fixed priority.
- Two read ports with write-through bypass.
- Optional hardwired-zero register 0 and optional registered (1-cycle) read.
- Per-register pending scoreboard so a sequencer can reserve a destination and stall readers until it is written.
Sits behind the board top-level clocking wrapper and is driven by the datapath/sequencer.

Parameters:
N, 8, number of registers (2..32)
W, 4, data width in bits
ADDR_W, 5, address width; addresses >= N are out of range
ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes/reservations
READ_REG, 0, 0: combinational read (latency 0); 1: registered read (latency 1)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
we_a  input  1  write enable, port A
addr_wa  input  ADDR_W  write address, port A
data_wa  input  W  write data, port A
we_b  input  1  write enable, port B (priority over A)
addr_wb  input  ADDR_W  write address, port B
data_wb  input  W  write data, port B
addr_rs1  input  ADDR_W  read address 1
addr_rs2  input  ADDR_W  read address 2
rsv_valid  input  1  reserve request: mark rsv_addr pending
rsv_addr  input  ADDR_W  register to reserve
rs1  output  W  read data 1
rs2  output  W  read data 2
busy_rs1  output  1  register at addr_rs1 is pending
busy_rs2  output  1  register at addr_rs2 is pending

Behaviour:
Reset (rst=1 at rising edge):
- All registers := 0; all pending bits := 0.
- READ_REG=1: rs1/rs2/busy_rs* registers := 0.
- Reset overrides every same-cycle write or reserve.
- Effective mid-operation; the cycle after reset, reads return 0.

Write:
- Port X is "active" when we_X=1, addr_wX<N, and not (ZERO_REG=1 and addr_wX=0).
- Active port updates the register at the edge.
- Both ports active on the same address: data_wb stored, data_wa discarded.
- Different addresses: both stored in the same cycle.
- Inactive writes have no effect.

Read value (combinational):
- addr_rsX >= N -> 0.
- ZERO_REG=1 and addr_rsX=0 -> 0.
- Else if active port B targets addr_rsX -> data_wb (bypass).
- Else if active port A targets addr_rsX -> data_wa (bypass).
- Else stored register value.

Read latency:
- READ_REG=0: value above drives rs1/rs2 directly.
- READ_REG=1: value above is registered; rs1/rs2 present it one cycle after the address. Bypassed data therefore appears the cycle after the write.

Scoreboard:
- pending[i] set at edge when rsv_valid=1 and rsv_addr=i, i<N, not (ZERO_REG=1 and i=0).
- pending[i] cleared at edge when any active write targets i.
- Reserve and write to the same i in the same cycle: reserve wins, pending[i]=1 (new producer supersedes the completing one).
- Reserving an already pending register: stays 1, no error.
- busy_rsX = pending[addr_rsX] AND no active write to addr_rsX this cycle. A completing write un-busies in the same cycle its data is bypassed.
- Out-of-range or zero-register addresses: busy 0.
- READ_REG=1: busy_rsX registered together with rsX, so data and busy stay aligned.

Width and range:
- No arithmetic; address compare on full ADDR_W bits, so aliasing of out-of-range addresses never occurs.
- W and N fully generic; no hardcoded 4/8.

Test Plan:
1. Reset then read all 8 addresses (READ_REG=0) -> rs1=rs2=0, busy=0. Write 0xA to r3 via A, then read r3 next cycle -> rs1=0xA.
2. Same-cycle we_a(r5,0x3) and we_b(r5,0xC) with addr_rs1=5 -> rs1=0xC combinationally; next cycle r5 reads 0xC.
3. ZERO_REG=1: we_a(r0,0xF) and rsv(r0) -> rs1(addr 0)=0, busy_rs1=0. Addresses 8 and 31 read 0; a write to 9 changes no register.
4. Scoreboard: rsv r2 -> busy_rs2=1 next cycle. Write r2=0x7 -> busy_rs2=0 and rs2=0x7 in the write cycle. Same-cycle rsv r2 + write r2 -> data stored, pending remains 1.
5. READ_REG=1: addr_rs1=4 while writing r4=0x9 -> rs1=0x9 exactly one cycle later, with busy_rs1 aligned.
6. Reset mid-operation: with r1=0x6 and r1 pending, assert rst while we_a(r1,0x2) -> after the edge r1 reads 0, busy=0.
